// File: rtl/cache_write_buffer_pkg.sv
// Shared types and defaults for the posted cache write buffer.
package cache_write_buffer_pkg;

  localparam int ADDR_W_DEF = 28;
  localparam int DATA_W_DEF = 128;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_MRD   = 2'd2,
    ST_RESP  = 2'd3
  } wb_state_e;

endpackage

// File: rtl/cache_write_buffer_wb_match.sv
// Combinational address CAM over the live buffer entries; reports the newest match
// (scan runs oldest to newest so the last hit wins) and whether that entry is being drained.
module wb_match #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 28,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0]             valid_i,
  input  logic [DEPTH-1:0][ADDR_W-1:0] addr_i,
  input  logic [IDX_W-1:0]             head_i,
  input  logic                         head_busy_i,
  input  logic [ADDR_W-1:0]            key_i,
  output logic                         hit_o,
  output logic [IDX_W-1:0]             idx_o,
  output logic                         inflight_o
);

  logic [IDX_W-1:0] pos;

  always_comb begin
    hit_o = 1'b0;
    idx_o = head_i;
    pos   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      pos = head_i + IDX_W'(i);
      if (valid_i[pos] && (addr_i[pos] == key_i)) begin
        hit_o = 1'b1;
        idx_o = pos;
      end
    end
    inflight_o = hit_o && head_busy_i && (idx_o == head_i);
  end

endmodule

// File: rtl/cache_write_buffer.sv
// Posted write buffer: 1-cycle write acks, background drain to memory, read forwarding.
// Cache handshake: a request is sampled only when not busy; c_ready pulses once per accepted request.
module cache_write_buffer
  import cache_write_buffer_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                    clk,
  input  logic                    proc_reset,
  input  logic                    c_read,
  input  logic                    c_write,
  input  logic [ADDR_W-1:0]       c_addr,
  input  logic [DATA_W-1:0]       c_wdata,
  output logic [DATA_W-1:0]       c_rdata,
  output logic                    c_ready,
  output logic                    mem_read,
  output logic                    mem_write,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [DATA_W-1:0]       mem_wdata,
  input  logic [DATA_W-1:0]       mem_rdata,
  input  logic                    mem_ready,
  output wb_state_e               dbg_state_o,
  output logic [$clog2(DEPTH):0]  dbg_count_o
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;

  logic [DEPTH-1:0][ADDR_W-1:0] addr_q;
  logic [DEPTH-1:0][DATA_W-1:0] data_q;
  logic [IDX_W-1:0]             head_q, tail_q;
  logic [CNT_W-1:0]             count_q;
  logic                         ack_q, guard_q, rd_pend_q;
  logic [DATA_W-1:0]            ack_data_q;
  logic [ADDR_W-1:0]            rd_addr_q;

  wb_state_e                    state_q;
  logic                         mem_read_q, mem_write_q, resp_q;
  logic [ADDR_W-1:0]            mem_addr_q;
  logic [DATA_W-1:0]            mem_wdata_q, resp_data_q;

  logic [DEPTH-1:0] valid;
  logic [IDX_W-1:0] off;
  logic             hit, hit_inflight, head_busy;
  logic [IDX_W-1:0] hit_idx;
  logic             busy, req_wr, req_rd, coalesce, push, pop_now, rd_hit, rd_miss;

  always_comb begin
    valid = '0;
    off   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off      = IDX_W'(i) - head_q;
      valid[i] = ({1'b0, off} < count_q);
    end
  end

  // The head counts as in flight from the cycle the FSM latches it, so it is never coalesced
  // on the same edge its data is copied to the memory port.
  assign head_busy = (state_q == ST_DRAIN) ||
                     ((state_q == ST_IDLE) && !rd_pend_q && (count_q != '0));

  wb_match #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .IDX_W(IDX_W)) u_match (
    .valid_i    (valid),
    .addr_i     (addr_q),
    .head_i     (head_q),
    .head_busy_i(head_busy),
    .key_i      (c_addr),
    .hit_o      (hit),
    .idx_o      (hit_idx),
    .inflight_o (hit_inflight)
  );

  assign c_ready  = ack_q | resp_q;
  assign busy     = rd_pend_q | c_ready | guard_q;
  assign req_wr   = c_write & ~c_read & ~busy;
  assign req_rd   = c_read & ~c_write & ~busy;
  assign pop_now  = (state_q == ST_DRAIN) & mem_ready;
  assign coalesce = req_wr & hit & ~hit_inflight;
  assign push     = req_wr & ~coalesce & ((count_q != CNT_W'(DEPTH)) | pop_now);
  assign rd_hit   = req_rd & hit;
  assign rd_miss  = req_rd & ~hit;

  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset) begin
      addr_q     <= '0;
      data_q     <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      ack_q      <= 1'b0;
      guard_q    <= 1'b0;
      rd_pend_q  <= 1'b0;
      ack_data_q <= '0;
      rd_addr_q  <= '0;
    end else begin
      ack_q   <= coalesce | push | rd_hit;
      guard_q <= c_ready;
      if (rd_hit) ack_data_q <= data_q[hit_idx];
      if (coalesce) data_q[hit_idx] <= c_wdata;
      if (push) begin
        addr_q[tail_q] <= c_addr;
        data_q[tail_q] <= c_wdata;
        tail_q         <= tail_q + 1'b1;
      end
      if (pop_now) head_q <= head_q + 1'b1;
      count_q <= count_q + CNT_W'(push) - CNT_W'(pop_now);
      if (rd_miss) begin
        rd_pend_q <= 1'b1;
        rd_addr_q <= c_addr;
      end else if ((state_q == ST_MRD) && mem_ready) begin
        rd_pend_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset) begin
      state_q     <= ST_IDLE;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      resp_q      <= 1'b0;
      resp_data_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (rd_pend_q) begin
            state_q    <= ST_MRD;
            mem_read_q <= 1'b1;
            mem_addr_q <= rd_addr_q;
          end else if (count_q != '0) begin
            state_q     <= ST_DRAIN;
            mem_write_q <= 1'b1;
            mem_addr_q  <= addr_q[head_q];
            mem_wdata_q <= data_q[head_q];
          end
        end
        ST_DRAIN: begin
          if (mem_ready) begin
            state_q     <= ST_IDLE;
            mem_write_q <= 1'b0;
          end
        end
        ST_MRD: begin
          if (mem_ready) begin
            state_q     <= ST_RESP;
            mem_read_q  <= 1'b0;
            resp_q      <= 1'b1;
            resp_data_q <= mem_rdata;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          resp_q  <= 1'b0;
        end
      endcase
    end
  end

  assign c_rdata     = ack_q ? ack_data_q : (resp_q ? resp_data_q : '0);
  assign mem_read    = mem_read_q;
  assign mem_write   = mem_write_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign dbg_state_o = state_q;
  assign dbg_count_o = count_q;

endmodule

// File: tb/tb_cache_write_buffer.sv
// Directed bench for cache_write_buffer: write ack, forwarding, coalescing, full stall,
// miss-read ordering behind a drain, and asynchronous reset mid-drain.
module tb_cache_write_buffer;
  import cache_write_buffer_pkg::*;

  localparam int AW = 28;
  localparam int DW = 128;
  localparam int W  = AW + DW;

  logic          clk = 1'b0;
  logic          proc_reset;
  logic          c_read, c_write;
  logic [AW-1:0] c_addr;
  logic [DW-1:0] c_wdata, c_rdata;
  logic          c_ready, mem_read, mem_write;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          mem_ready;
  wb_state_e     dbg_state;
  logic [2:0]    dbg_count;

  logic [W-1:0]  exp_q[$];
  int            n_checks = 0;
  int            n_pass = 0;
  logic          saw_mem_read = 1'b0;

  always #5 clk = ~clk;

  cache_write_buffer #(.DEPTH(4), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk        (clk),
    .proc_reset (proc_reset),
    .c_read     (c_read),
    .c_write    (c_write),
    .c_addr     (c_addr),
    .c_wdata    (c_wdata),
    .c_rdata    (c_rdata),
    .c_ready    (c_ready),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready),
    .dbg_state_o(dbg_state),
    .dbg_count_o(dbg_count)
  );

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // Memory-side scoreboard: every completed drain must match the next expected write.
  always @(negedge clk) begin
    if (!proc_reset && mem_read) saw_mem_read = 1'b1;
    if (!proc_reset && mem_write && mem_ready) begin
      check("drain_expected", W'(exp_q.size() != 0), W'(1));
      if (exp_q.size() != 0) check("drain_beat", {mem_addr, mem_wdata}, exp_q.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    proc_reset = 1'b1;
    c_read = 1'b0; c_write = 1'b0; c_addr = '0; c_wdata = '0;
    mem_ready = 1'b0; mem_rdata = '0;
    exp_q.delete();
    tick(); tick();
    check("rst_c_ready", W'(c_ready), W'(0));
    check("rst_mem_req", W'({mem_read, mem_write}), W'(0));
    check("rst_mem_bus", {mem_addr, mem_wdata}, W'(0));
    check("rst_state_count", W'({dbg_state, dbg_count}), W'(0));
    proc_reset = 1'b0;
    tick();
  endtask

  task automatic cache_req(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           output int lat, output logic [DW-1:0] rd);
    c_write = wr; c_read = ~wr; c_addr = a; c_wdata = d;
    lat = -1; rd = '0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (c_ready) begin
        lat = i;
        rd  = c_rdata;
        break;
      end
    end
    c_write = 1'b0; c_read = 1'b0;
    tick(); tick();
  endtask

  task automatic mem_pulse(input logic [DW-1:0] d);
    mem_rdata = d;
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
  endtask

  task automatic wait_mem_write(input string tag);
    int n = 0;
    while (!mem_write && n < 10) begin tick(); n++; end
    check(tag, W'(mem_write), W'(1));
  endtask

  task automatic wait_mem_read(input string tag);
    int n = 0;
    while (!mem_read && n < 10) begin tick(); n++; end
    check(tag, W'(mem_read), W'(1));
  endtask

  function automatic logic [DW-1:0] pat(input int i);
    logic [31:0] w;
    w = 32'h4000_0000 + 32'(i);
    return {w, ~w, w, 32'hC0DE_0000 ^ w};
  endfunction

  initial begin
    int            lat, acks, held;
    logic [DW-1:0] rd;
    logic [DW-1:0] d0, d1, d2, d3, d4, da, dr5, dr6;
    d0 = {4{32'hD000_0000}}; d1 = {4{32'hD111_1111}}; d2 = {4{32'hD222_2222}};
    d3 = {4{32'hD333_3333}}; d4 = {4{32'hD444_4444}}; da = {4{32'hDAAA_AAAA}};
    dr5 = {4{32'h5555_A5A5}}; dr6 = {4{32'h6666_C3C3}};

    // 1: single write, ack after 1 cycle, drained after a 5-cycle memory wait
    do_reset();
    exp_q.push_back({28'h0000010, d0});
    cache_req(1'b1, 28'h0000010, d0, lat, rd);
    check("t1_ack_lat", W'(lat), W'(1));
    check("t1_mem_write", W'(mem_write), W'(1));
    check("t1_mem_bus", {mem_addr, mem_wdata}, {28'h0000010, d0});
    tick(); tick(); tick();
    mem_pulse('0);
    check("t1_count", W'(dbg_count), W'(0));
    check("t1_write_drop", W'(mem_write), W'(0));

    // 2: read hits the in-flight entry while memory is stalled
    do_reset();
    saw_mem_read = 1'b0;
    cache_req(1'b1, 28'h20, d1, lat, rd);
    check("t2_wr_lat", W'(lat), W'(1));
    cache_req(1'b0, 28'h20, '0, lat, rd);
    check("t2_rd_lat", W'(lat), W'(1));
    check("t2_rd_data", W'(rd), W'(d1));
    check("t2_no_mem_read", W'(saw_mem_read), W'(0));

    // 3: second write to a queued (not in-flight) address coalesces
    do_reset();
    exp_q.push_back({28'h38, da});
    exp_q.push_back({28'h30, d3});
    cache_req(1'b1, 28'h38, da, lat, rd);
    cache_req(1'b1, 28'h30, d2, lat, rd);
    cache_req(1'b1, 28'h30, d3, lat, rd);
    check("t3_coalesce_lat", W'(lat), W'(1));
    check("t3_count", W'(dbg_count), W'(2));
    wait_mem_write("t3_drain0_start");
    mem_pulse('0);
    wait_mem_write("t3_drain1_start");
    mem_pulse('0);
    tick();
    check("t3_empty", W'(dbg_count), W'(0));

    // 4: full buffer withholds the 5th ack until a drain pops an entry
    do_reset();
    acks = 0;
    for (int i = 0; i < 4; i++) begin
      cache_req(1'b1, 28'h100 + 28'(i), pat(i), lat, rd);
      if (lat == 1) acks++;
    end
    check("t4_acks", W'(acks), W'(4));
    check("t4_full", W'(dbg_count), W'(4));
    c_write = 1'b1; c_addr = 28'h104; c_wdata = pat(4);
    held = 0;
    repeat (3) begin
      tick();
      if (c_ready) held++;
    end
    check("t4_withheld", W'(held), W'(0));
    exp_q.push_back({28'h100, pat(0)});
    mem_pulse('0);
    check("t4_ack_after_pop", W'(c_ready), W'(1));
    c_write = 1'b0;
    tick(); tick();
    check("t4_still_full", W'(dbg_count), W'(4));
    for (int i = 1; i <= 4; i++) begin
      exp_q.push_back({28'h100 + 28'(i), pat(i)});
      wait_mem_write("t4_drain_start");
      mem_pulse('0);
    end
    tick();
    check("t4_empty", W'(dbg_count), W'(0));

    // 5: miss read waits for the in-flight drain, then goes to memory
    do_reset();
    cache_req(1'b1, 28'h40, d4, lat, rd);
    c_read = 1'b1; c_addr = 28'h50;
    tick(); tick();
    check("t5_no_early_ack", W'(c_ready), W'(0));
    check("t5_no_early_read", W'(mem_read), W'(0));
    exp_q.push_back({28'h40, d4});
    mem_pulse('0);
    tick();
    check("t5_mem_read", W'(mem_read), W'(1));
    check("t5_mem_addr", W'(mem_addr), W'(28'h50));
    check("t5_no_write", W'(mem_write), W'(0));
    mem_pulse(dr5);
    check("t5_ack", W'(c_ready), W'(1));
    check("t5_rdata", W'(c_rdata), W'(dr5));
    c_read = 1'b0;
    check("t5_read_drop", W'(mem_read), W'(0));
    tick(); tick();

    // 6: asynchronous reset mid-drain abandons the buffer
    do_reset();
    cache_req(1'b1, 28'h40, pat(10), lat, rd);
    cache_req(1'b1, 28'h41, pat(11), lat, rd);
    cache_req(1'b1, 28'h42, pat(12), lat, rd);
    check("t6_pre_state", W'(dbg_state), W'(ST_DRAIN));
    check("t6_pre_count", W'(dbg_count), W'(3));
    #2;
    proc_reset = 1'b1;
    #1;
    check("t6_rst_mem_write", W'(mem_write), W'(0));
    check("t6_rst_c_ready", W'(c_ready), W'(0));
    check("t6_rst_count", W'(dbg_count), W'(0));
    tick();
    proc_reset = 1'b0;
    tick();
    c_read = 1'b1; c_addr = 28'h40;
    wait_mem_read("t6_read_to_mem");
    check("t6_read_addr", W'(mem_addr), W'(28'h40));
    mem_pulse(dr6);
    check("t6_ack", W'(c_ready), W'(1));
    check("t6_rdata", W'(c_rdata), W'(dr6));
    c_read = 1'b0;
    tick(); tick();

    check("end_exp_q_empty", W'(exp_q.size()), W'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
